// File: rtl/fir_coef_loader.sv
// Coefficient loader for one fir_filter: shadows SW-written taps, shifts them into the
// filter's cfg_din/cfg_ce chain on start, and mutes the filter output until its pipeline has flushed.
module fir_coef_loader #(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [24:0]       wr_data,
  input  logic              start,
  input  logic [31:0]       filt_len,
  output logic [24:0]       cfg_din,
  output logic              cfg_ce,
  output logic              mute,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);

  state_t            state_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   len_reg;
  logic [24:0]       shadow_mem [MAX_LEN];

  logic              len_ok;
  logic              wr_in_range;
  logic              wr_accept;
  logic              last_count;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [24:0]       rd_word;

  always_comb begin
    len_ok      = (filt_len != 32'd0) && (filt_len <= MAX_LEN_W);
    wr_in_range = {{(32-ADDR_W){1'b0}}, wr_addr} < MAX_LEN_W;
    wr_accept   = reset && (state_reg == IDLE) && wr_en && wr_in_range;
    last_count  = (count_reg == len_reg - (ADDR_W+1)'(1));
    // Word for the cycle after this one: top tap first, then walk down to buf[0].
    first_addr  = filt_len[ADDR_W-1:0] - ADDR_W'(1);
    next_addr   = ADDR_W'(len_reg - count_reg - (ADDR_W+1)'(2));
    rd_addr     = (state_reg == IDLE) ? first_addr : next_addr;
    // A write in the same cycle as start must be seen by the first shifted word.
    if (wr_accept && (wr_addr == rd_addr))
      rd_word = wr_data;
    else
      rd_word = shadow_mem[rd_addr];
  end

  // Shadow buffer has no reset so SW-written taps survive a reset.
  always_ff @(posedge clk) begin
    if (wr_accept)
      shadow_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      len_reg   <= '0;
      cfg_din   <= '0;
      cfg_ce    <= 1'b0;
      mute      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= wr_en && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          cfg_ce  <= 1'b0;
          cfg_din <= '0;
          mute    <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            if (len_ok) begin
              state_reg <= LOAD;
              len_reg   <= filt_len[ADDR_W:0];
              count_reg <= '0;
              cfg_ce    <= 1'b1;
              cfg_din   <= rd_word;
              mute      <= 1'b1;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (last_count) begin
            state_reg <= FLUSH;
            count_reg <= '0;
            cfg_ce    <= 1'b0;
            cfg_din   <= '0;
          end else begin
            count_reg <= count_reg + (ADDR_W+1)'(1);
            cfg_din   <= rd_word;
          end
        end
        FLUSH: begin
          if (last_count) begin
            state_reg <= DONE;
            count_reg <= '0;
            done      <= 1'b1;
          end else begin
            count_reg <= count_reg + (ADDR_W+1)'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          count_reg <= '0;
          mute      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
          cfg_ce    <= 1'b0;
          cfg_din   <= '0;
          mute      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: randomized buffer contents and loads checked
// cycle by cycle against a reference trace derived from the shadow buffer model.
module tb_fir_coef_loader;

  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [24:0] wr_data = '0;
  logic        start = 1'b0;
  logic [31:0] filt_len = '0;
  logic [24:0] cfg_din;
  logic        cfg_ce, mute, busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [24:0] model [MAX_LEN];

  fir_coef_loader #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .filt_len(filt_len), .cfg_din(cfg_din), .cfg_ce(cfg_ce),
    .mute(mute), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] obs();
    return {cfg_ce, cfg_din, mute, busy, done, err};
  endfunction

  task automatic write_word(input logic [5:0] a, input logic [24:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Starts a load of n taps and checks every cycle until the block is idle again.
  // wr_k / st_k inject a write or an extra start after the given cycle (-1 = none).
  task automatic run_load(input string tag, input int n, input int wr_k,
                          input logic [5:0] waddr, input logic [24:0] wdata, input int st_k);
    logic [29:0] exp_v, got;
    logic [24:0] words[$];
    int bad;
    bad = 0;
    words = {};
    for (int i = n - 1; i >= 0; i--) words.push_back(model[i]);
    start = 1'b1; filt_len = n;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; filt_len = $urandom;
    for (int k = 0; k <= 2 * n + 1; k++) begin
      exp_v = {(k < n), (k < n) ? words[k] : 25'd0, (k <= 2 * n), (k <= 2 * n),
               (k == 2 * n), (wr_k >= 0 && k == wr_k + 1)};
      got = obs();
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        bad++;
        $display("FAIL %s len=%0d cycle %0d: got ce=%0b din=%h mute=%0b busy=%0b done=%0b err=%0b, expected ce=%0b din=%h mute=%0b busy=%0b done=%0b err=%0b",
                 tag, n, k, got[29], got[28:4], got[3], got[2], got[1], got[0],
                 exp_v[29], exp_v[28:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
      wr_en = (k == wr_k);
      if (k == wr_k) begin wr_addr = waddr; wr_data = wdata; end
      start = (k == st_k);
      if (k == st_k) filt_len = $urandom_range(1, MAX_LEN);
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    $display("[TB] %s: load len=%0d wr_k=%0d st_k=%0d, %0d bad cycles", tag, n, wr_k, st_k, bad);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (obs() !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h, expected 0", obs());
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (obs() !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_release: got %h, expected 0", obs());
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    for (int a = 0; a < 4; a++) write_word(6'(a), 25'(a + 1));
    run_load("basic", 4, -1, 6'd0, 25'd0, -1);
  endtask

  task automatic test_bad_len();
    logic [31:0] lens [5];
    lens[0] = 32'd0; lens[1] = 32'd65; lens[2] = 32'd132; lens[3] = 32'hFFFF_FFFF;
    lens[4] = 32'd65 + $urandom_range(0, 100000);
    foreach (lens[i]) begin
      start = 1'b1; filt_len = lens[i];
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (obs() !== 30'd1) begin
        tests_failed++;
        $display("FAIL bad_len_err len=%0d: got ce=%0b busy=%0b err=%0b, expected ce=0 busy=0 err=1",
                 lens[i], cfg_ce, busy, err);
      end
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        tests_run++;
        if (obs() !== 30'd0) begin
          tests_failed++;
          $display("FAIL bad_len_idle len=%0d: got %h, expected 0", lens[i], obs());
        end
      end
      $display("[TB] rejected start len=%0d", lens[i]);
    end
  endtask

  task automatic test_full();
    for (int a = 0; a < MAX_LEN; a++) write_word(6'(a), 25'(a + 'h100));
    run_load("full", MAX_LEN, -1, 6'd0, 25'd0, -1);
  endtask

  task automatic test_write_busy();
    for (int a = 0; a < 4; a++) write_word(6'(a), 25'($urandom));
    run_load("wr_busy", 4, 1, 6'd2, 25'($urandom), -1);
    run_load("wr_busy_reload", 4, -1, 6'd0, 25'd0, -1);
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < 8; a++) write_word(6'(a), 25'($urandom));
    start = 1'b1; filt_len = 8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      tests_run++;
      if (cfg_ce !== 1'b1 || cfg_din !== model[7 - k]) begin
        tests_failed++;
        $display("FAIL reset_mid_load cycle %0d: got ce=%0b din=%h, expected ce=1 din=%h",
                 k, cfg_ce, cfg_din, model[7 - k]);
      end
      if (k == 2) reset = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tests_run++;
      if (obs() !== 30'd0) begin
        tests_failed++;
        $display("FAIL reset_mid_idle cycle %0d: got %h, expected 0", c, obs());
      end
      @(negedge clk);
    end
    $display("[TB] mid-load reset aborted load");
    run_load("after_reset", 8, -1, 6'd0, 25'd0, -1);
  endtask

  task automatic test_wr_with_start();
    wr_en = 1'b1; wr_addr = 6'd0; wr_data = 25'h55;
    model[0] = 25'h55;
    run_load("wr_start", 1, -1, 6'd0, 25'd0, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n, wk, sk;
      for (int w = 0; w < 6; w++) write_word(6'($urandom_range(0, MAX_LEN - 1)), 25'($urandom));
      n  = (t % 3 == 0) ? $urandom_range(1, 4) : $urandom_range(1, MAX_LEN);
      wk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2 * n) : -1;
      sk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n) : -1;
      run_load("random", n, wk, 6'($urandom), 25'($urandom), sk);
    end
  endtask

  initial begin
    for (int a = 0; a < MAX_LEN; a++) model[a] = 'x;
    test_reset();
    test_basic();
    test_bad_len();
    test_full();
    test_write_busy();
    test_reset_mid();
    test_wr_with_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
